// File: rtl/bcd_conversion_sequencer_pkg.sv
// rtl/bcd_conversion_sequencer_pkg.sv - shared types, defaults and arbitration helper
package bcd_conversion_sequencer_pkg;

    localparam int BCD_WIDTH_DEFAULT  = 32;
    localparam int BCD_DIGITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Lone requester wins; on a tie the holder of the priority token wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic pri);
        return req[1] & (~req[0] | pri);
    endfunction

endpackage

// File: rtl/bcd_conversion_sequencer_if.sv
// rtl/bcd_conversion_sequencer_if.sv - request/result bundle between clients and the converter
interface bcd_conversion_sequencer_if
    import bcd_conversion_sequencer_pkg::*;
#(
    parameter int WIDTH  = BCD_WIDTH_DEFAULT,
    parameter int DIGITS = BCD_DIGITS_DEFAULT
) ();

    logic [1:0]          req;
    logic [WIDTH-1:0]    bin0;
    logic [WIDTH-1:0]    bin1;
    logic [1:0]          grant;
    logic                busy;
    logic                done;
    logic                done_id;
    logic [4*DIGITS-1:0] bcd;
    logic                overflow;

    modport master (
        output req, bin0, bin1,
        input  grant, busy, done, done_id, bcd, overflow
    );

    modport slave (
        input  req, bin0, bin1,
        output grant, busy, done, done_id, bcd, overflow
    );

endinterface

// File: rtl/bcd_conversion_sequencer_dabble_step.sv
// rtl/bcd_conversion_sequencer_dabble_step.sv - one combinational add-3 then shift-left step
module bcd_conversion_sequencer_dabble_step #(
    parameter int DIGITS = 8
) (
    input  logic [4*DIGITS-1:0] digits_i,
    input  logic                shift_in_i,
    output logic [4*DIGITS-1:0] digits_o,
    output logic                shift_out_o
);

    logic [4*DIGITS-1:0] adj;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] d;
        assign d = digits_i[4*k +: 4];
        assign adj[4*k +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end

    assign digits_o    = {adj[4*DIGITS-2:0], shift_in_i};
    assign shift_out_o = adj[4*DIGITS-1];

endmodule

// File: rtl/bcd_conversion_sequencer.sv
// rtl/bcd_conversion_sequencer.sv - two-client round-robin sequencer around a serial double-dabble engine
module bcd_conversion_sequencer
    import bcd_conversion_sequencer_pkg::*;
#(
    parameter int WIDTH  = BCD_WIDTH_DEFAULT,
    parameter int DIGITS = BCD_DIGITS_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset_n,
    bcd_conversion_sequencer_if.slave     bus
);

    localparam int CW = $clog2(WIDTH);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             pri_q, pri_d;
    logic             win_q, win_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [BW-1:0]    work_q, work_d;
    logic             ovf_work_q, ovf_work_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       grant_q, grant_d;

    logic [BW-1:0]    step_digits;
    logic             step_out;
    logic             win_pick;

    bcd_conversion_sequencer_dabble_step #(.DIGITS(DIGITS)) u_step (
        .digits_i    (work_q),
        .shift_in_i  (opnd_q[WIDTH-1]),
        .digits_o    (step_digits),
        .shift_out_o (step_out)
    );

    always_comb begin
        state_d    = state_q;
        pri_d      = pri_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        grant_d    = grant_q;
        win_pick   = pick_winner(bus.req, pri_q);

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    win_d      = win_pick;
                    opnd_d     = win_pick ? bus.bin1 : bus.bin0;
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_LOAD;
                    grant_d    = win_pick ? 2'b10 : 2'b01;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d     = step_digits;
                opnd_d     = {opnd_q[WIDTH-2:0], 1'b0};
                ovf_work_d = ovf_work_q | step_out;
                if (cnt_q == '0) begin
                    // Publish on the final step so the result lands with DONE entry.
                    bcd_d   = step_digits;
                    ovf_d   = ovf_work_q | step_out;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                pri_d   = ~win_q;
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Priority token starts with requester 0 and is handed to the loser after each service.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pri_q      <= 1'b0;
            win_q      <= 1'b0;
            cnt_q      <= '0;
            opnd_q     <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            pri_q      <= pri_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            grant_q    <= grant_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.done_id  = win_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_conversion_sequencer.sv
// tb/tb_bcd_conversion_sequencer.sv - randomized and directed bench against a cycle-count reference model
module tb_bcd_conversion_sequencer;

    localparam int W   = 32;
    localparam int D   = 8;
    localparam int LAT = W + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bcd_conversion_sequencer_if #(.WIDTH(W), .DIGITS(D)) bus ();

    bcd_conversion_sequencer #(.WIDTH(W), .DIGITS(D)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] to_bcd(input longint unsigned v);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: a conversion occupies cycles t+1..t+LAT+1 after the request is seen idle.
    bit          m_busy  = 0;
    int          m_cnt   = 0;
    bit          m_win   = 0;
    bit          m_last  = 1;
    bit          m_done  = 0;
    bit          m_id    = 0;
    logic [1:0]  m_grant = 2'b00;
    logic [31:0] m_val   = '0;
    logic [31:0] m_bcd   = '0;
    bit          m_ovf   = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_cnt = 0; m_win = 0; m_last = 1; m_done = 0; m_id = 0;
            m_grant = 2'b00; m_val = '0; m_bcd = '0; m_ovf = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == LAT) begin
                m_done = 1;
                m_id   = m_win;
                m_bcd  = to_bcd(longint'(m_val));
                m_ovf  = (longint'(m_val) >= 64'd100000000);
                m_last = m_win;
            end else if (m_cnt == LAT + 1) begin
                m_busy  = 0;
                m_done  = 0;
                m_grant = 2'b00;
            end
        end else if (bus.req != 2'b00) begin
            if (bus.req == 2'b11) m_win = ~m_last;
            else                  m_win = (bus.req == 2'b10);
            m_val   = m_win ? bus.bin1 : bus.bin0;
            m_busy  = 1;
            m_cnt   = 1;
            m_grant = m_win ? 2'b10 : 2'b01;
        end
    end

    always @(negedge clock) begin
        chk("grant", bus.grant, m_grant);
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        if (m_done) chk("done_id", bus.done_id, m_id);
        chk("bcd", bus.bcd, m_bcd);
        chk("overflow", bus.overflow, m_ovf);
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_done(output bit id, output logic [31:0] b, output bit ov, output int n);
        n = 0; id = 0; b = '0; ov = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.done && n < 200);
        if (!bus.done) begin
            n_total++;
            $display("FAIL wait_done: no done within %0d cycles", n);
        end else begin
            id = bus.done_id;
            b  = bus.bcd;
            ov = bus.overflow;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [4];
        edges[0] = 32'd99999999; edges[1] = 32'd100000000;
        edges[2] = 32'd0;        edges[3] = 32'hFFFFFFFF;
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 999));
            1:       return 32'($urandom_range(0, 99999999));
            2:       return 32'($urandom);
            default: return edges[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          id;
        logic [31:0] b;
        bit          ov;
        int          n;

        bus.req = 2'b00; bus.bin0 = '0; bus.bin1 = '0;
        chk("model_pin_a", to_bcd(64'd12345678), 64'h12345678);
        chk("model_pin_b", to_bcd(64'hFFFFFFFF), 64'h94967295);
        repeat (3) cyc();
        chk("reset_bcd", bus.bcd, 0);
        chk("reset_grant", bus.grant, 0);
        reset_n = 1'b1;
        cyc();

        bus.req = 2'b01; bus.bin0 = 32'd0;
        wait_done(id, b, ov, n);
        chk("t1_latency", n, 33); chk("t1_id", id, 0); chk("t1_bcd", b, 0); chk("t1_ovf", ov, 0);
        bus.req = 2'b00; repeat (2) cyc();

        bus.req = 2'b10; bus.bin1 = 32'd12345678;
        wait_done(id, b, ov, n);
        chk("t2_id", id, 1); chk("t2_bcd", b, 32'h12345678); chk("t2_ovf", ov, 0);
        bus.req = 2'b00; repeat (2) cyc();

        bus.req = 2'b01; bus.bin0 = 32'hFFFFFFFF;
        wait_done(id, b, ov, n);
        chk("t3_max_bcd", b, 32'h94967295); chk("t3_max_ovf", ov, 1);
        bus.req = 2'b00; cyc();
        bus.req = 2'b01; bus.bin0 = 32'd99999999;
        wait_done(id, b, ov, n);
        chk("t3_99m_bcd", b, 32'h99999999); chk("t3_99m_ovf", ov, 0);
        bus.req = 2'b00; repeat (5) cyc();
        bus.req = 2'b01; bus.bin0 = 32'd7;
        repeat (4) cyc();
        chk("t3_hold_bcd", bus.bcd, 32'h99999999);
        wait_done(id, b, ov, n);
        bus.req = 2'b00; cyc();

        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        bus.bin0 = 32'd5; bus.bin1 = 32'd7; bus.req = 2'b11;
        wait_done(id, b, ov, n);
        chk("t4_id0", id, 0); chk("t4_bcd0", b, 5); chk("t4_lat0", n, 33);
        wait_done(id, b, ov, n);
        chk("t4_id1", id, 1); chk("t4_bcd1", b, 7); chk("t4_gap1", n, 34);
        wait_done(id, b, ov, n);
        chk("t4_id2", id, 0); chk("t4_bcd2", b, 5); chk("t4_gap2", n, 34);
        bus.req = 2'b00; repeat (3) cyc();

        bus.req = 2'b01; bus.bin0 = 32'd123456;
        repeat (11) cyc();
        reset_n = 1'b0;
        cyc();
        chk("t5_busy", bus.busy, 0); chk("t5_grant", bus.grant, 0);
        chk("t5_done", bus.done, 0); chk("t5_bcd", bus.bcd, 0);
        bus.req = 2'b00; cyc();
        reset_n = 1'b1;
        repeat (40) cyc();
        bus.req = 2'b01; bus.bin0 = 32'd1000;
        wait_done(id, b, ov, n);
        chk("t5_bcd_after", b, 32'h00001000);
        bus.req = 2'b00; cyc();

        bus.req = 2'b01; bus.bin0 = 32'd4321;
        repeat (5) cyc();
        bus.bin0 = 32'd9999; bus.req = 2'b00;
        wait_done(id, b, ov, n);
        chk("t6_bcd", b, 32'h00004321); chk("t6_lat", n, 28);
        repeat (40) cyc();

        for (int it = 0; it < 80; it++) begin
            bus.req  = 2'($urandom_range(0, 3));
            bus.bin0 = rand_operand();
            bus.bin1 = rand_operand();
            for (int c = $urandom_range(1, 45); c > 0; c--) begin
                cyc();
                if ($urandom_range(0, 9) == 0) bus.bin0 = rand_operand();
                if ($urandom_range(0, 9) == 0) bus.bin1 = rand_operand();
            end
        end
        bus.req = 2'b00;
        repeat (40) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
